fifo_rd_stream: RTL and testbench
=================================

# fifo_rd_stream

Read-side output stage of the async FIFO. It sits directly downstream of the read-pointer/empty logic and the dual-port memory in the read clock domain. It drives `rinc`, captures the memory's combinational read data, and presents it on a registered valid/ready stream. A 2-entry buffer gives full throughput without a combinational path from `m_ready` to `rinc`.

## Interface
- `DSIZE`, default 8: data word width.
- `CNT_W`, default 16: width of the transfer counter.
- `rclk` input 1: read-domain clock; all state is on the rising edge.
- `rrst` input 1: reset, asynchronous, active-high.
- `rempty` input 1: registered FIFO empty flag from the read-pointer logic.
- `rdata` input DSIZE: memory read data. It is combinationally valid for the current read address whenever `rempty`=0.
- `rinc` output 1: read pop request to the read-pointer logic.
- `flush` input 1: synchronous discard of buffered words.
- `m_valid` output 1: output word valid.
- `m_data` output DSIZE: output word.
- `m_ready` input 1: downstream accept.
- `level` output 2: buffer occupancy, 0..2.
- `xfer_cnt` output CNT_W: count of accepted output words, wraps modulo 2^CNT_W.

## Operation
- **Buffer.** Two registers, `ent0` (head) and `ent1`, plus occupancy `level`.
  - `m_valid` = (`level` != 0).
  - `m_data` = `ent0`.
- **Pop and push.**
  - pop = `m_valid` & `m_ready`.
  - push = `rinc`.
  - `rinc` = ~`rrst` & ~`rempty` & ~`flush` & (`level` != 2). It is a function of registered state and `flush` only; it never depends on `m_ready`.
- **Next state**, when `flush`=0:
  - Only pop: `ent0` <= `ent1`; `level` -1.
  - Only push: `rdata` is written to `ent0` if `level`=0, or to `ent1` if `level`=1; `level` +1.
  - Pop and push together:
    - At `level`=1, `ent0` <= `rdata`.
    - At `level`=2, push cannot occur.
    - `level` is unchanged.
  - Neither: hold.
- **Flush.**
  - `level` <= 0 and `rinc`=0 in the flush cycle.
  - A handshake in the flush cycle (`m_valid`&`m_ready`) is a real transfer and is counted.
  - Entry contents after flush are don't-care, but `m_data` must not be read while `m_valid`=0.
- **Counter.** `xfer_cnt` increments by 1 on every pop and wraps from 2^CNT_W-1 to 0. `flush` does not clear it.
- **Ordering.** Words leave in exactly the order popped from the FIFO. No duplication, no loss except by `flush`.
- **Width rule.** `level` is held in 2 bits. Values 3 and above are unreachable, and the bench asserts this.

## Timing
- **Reset** (`rrst`=1, asynchronous assert): `m_valid`=0, `level`=0, `xfer_cnt`=0, `ent0`=`ent1`=0, `rinc`=0.
  - Deassertion is synchronous to `rclk` upstream.
  - The first `rinc` can occur in the first cycle after release with `rempty`=0.
- **Latency.** `rinc` high in cycle N puts that word on `m_data` with `m_valid`=1 in cycle N+1 (when it is the head).
- **Throughput.** One word per cycle sustained with `m_ready`=1 and the FIFO non-empty.
  - Steady state is `level`=1, with simultaneous push and pop.
- **Backpressure.** With `m_ready`=0, at most 2 words are popped; `rinc` then stays 0.
- **Stream rules.** Once `m_valid`=1, `m_valid` and `m_data` are held until accepted or flushed.
- **Empty.** `rempty`=1 forces `rinc`=0. `rempty` is registered upstream from the next-pointer compare, so a pop of the last word is followed by `rempty`=1 in the next cycle. No over-read is possible.
- **Reset mid-operation.** Buffered words are lost, `m_valid` drops immediately, and the counter clears. Upstream pointers are reset by their own reset.

## Test plan
- **Reset.** Assert `rrst` asynchronously mid-cycle with `level`=2 -> `m_valid`, `level`, `xfer_cnt`, `rinc` all 0 before the next edge; after release with `rempty`=1, `rinc` stays 0.
- **Single word.** FIFO holds 0xA5, `m_ready`=1 -> `rinc`=1 for exactly one cycle; next cycle `m_valid`=1, `m_data`=0xA5; `xfer_cnt`=1 afterwards; `level` returns to 0.
- **Streaming.** Write 0x00..0x0F, hold `m_ready`=1 -> 16 consecutive `m_valid` cycles, data 0x00..0x0F in order, `xfer_cnt`=16, no gaps after the first word.
- **Backpressure.**
  - Load 8 words, `m_ready`=0 -> exactly 2 `rinc` pulses, `level`=2, `m_data`=word0 held.
  - Then `m_ready`=1 -> words 0..7 delivered in order with no loss.
- **Flush.** `level`=2 with `m_ready`=1 in the flush cycle -> word0 counted (`xfer_cnt`+1), word1 discarded, `rinc`=0 that cycle; next cycle `m_valid`=0, then the stream resumes with word2.
- **Wrap.** `CNT_W`=4, 17 transfers -> `xfer_cnt` reads 15 after 15 transfers, 0 after 16, 1 after 17.

Source files
------------

// File: rtl/fifo_rd_stream.sv
// Read-side output stage of the async FIFO: pops words from the FIFO memory into a
// 2-entry skid buffer and presents them on a registered valid/ready stream.
module fifo_rd_stream #(
    parameter int DSIZE = 8,
    parameter int CNT_W = 16
) (
    input  logic             rclk,
    input  logic             rrst,
    input  logic             rempty,
    input  logic [DSIZE-1:0] rdata,
    output logic             rinc,
    input  logic             flush,
    output logic             m_valid,
    output logic [DSIZE-1:0] m_data,
    input  logic             m_ready,
    output logic [1:0]       level,
    output logic [CNT_W-1:0] xfer_cnt
);

    // Stream handshake: a word transfers on any rising edge where m_valid and m_ready
    // are both high; once raised, m_valid/m_data hold until that transfer or a flush.
    logic [DSIZE-1:0] ent0;
    logic [DSIZE-1:0] ent1;
    logic             pop;
    logic             push;

    // The pop request looks only at registered occupancy, so m_ready never reaches rinc.
    assign rinc    = ~rrst & ~rempty & ~flush & (level != 2'd2);
    assign m_valid = (level != 2'd0);
    assign m_data  = ent0;
    assign pop     = m_valid & m_ready;
    assign push    = rinc;

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            ent0     <= '0;
            ent1     <= '0;
            level    <= 2'd0;
            xfer_cnt <= '0;
        end else begin
            if (pop) begin
                xfer_cnt <= xfer_cnt + 1'b1;
            end
            if (flush) begin
                level <= 2'd0;
            end else begin
                unique case ({push, pop})
                    2'b01: begin
                        ent0  <= ent1;
                        level <= level - 2'd1;
                    end
                    2'b10: begin
                        if (level == 2'd0) begin
                            ent0 <= rdata;
                        end else begin
                            ent1 <= rdata;
                        end
                        level <= level + 2'd1;
                    end
                    // Push needs level<2 and pop needs level>0, so this is level 1.
                    2'b11: begin
                        ent0 <= rdata;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: an upstream FIFO model plus a queue-based reference of
// the words popped but not yet delivered, driven with random and directed traffic.
module tb_fifo_rd_stream;

    logic        rclk;
    logic        rrst;
    logic        rempty;
    logic [7:0]  rdata;
    logic        rinc;
    logic        flush;
    logic        m_valid;
    logic [7:0]  m_data;
    logic        m_ready;
    logic [1:0]  level;
    logic [15:0] xfer_cnt;

    logic        rinc4;
    logic        m_valid4;
    logic [7:0]  m_data4;
    logic [1:0]  level4;
    logic [3:0]  xfer_cnt4;

    logic [7:0] fifo_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] deliv_q[$];
    int exp_cnt;
    int pops;
    int rinc_pulses;
    int valid_cycles;
    int cyc;
    int first_pop_cyc;
    int last_pop_cyc;
    int checks;
    int failures;

    fifo_rd_stream #(.DSIZE(8), .CNT_W(16)) dut (
        .rclk(rclk), .rrst(rrst), .rempty(rempty), .rdata(rdata), .rinc(rinc),
        .flush(flush), .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
        .level(level), .xfer_cnt(xfer_cnt)
    );

    fifo_rd_stream #(.DSIZE(8), .CNT_W(4)) dut4 (
        .rclk(rclk), .rrst(rrst), .rempty(rempty), .rdata(rdata), .rinc(rinc4),
        .flush(flush), .m_valid(m_valid4), .m_data(m_data4), .m_ready(m_ready),
        .level(level4), .xfer_cnt(xfer_cnt4)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    always @(negedge rclk) begin
        if (!rrst) begin
            assert (level != 2'd3 && level4 != 2'd3)
            else begin
                failures++;
                $display("FAIL level_range: level=%0d level4=%0d, required <= 2", level, level4);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One clock cycle: drive inputs, score the stream against the reference, advance upstream.
    task automatic cycle(input logic rdy, input logic fl);
        logic exp_rinc;
        logic [7:0] w;
        m_ready = rdy;
        flush   = fl;
        rdata   = (fifo_q.size() != 0) ? fifo_q[0] : 8'($urandom);
        #1;
        checks++;
        if (level !== 2'(exp_q.size()))
            begin failures++; $display("FAIL sb_level: got %0d exp %0d", level, exp_q.size()); end
        checks++;
        if (m_valid !== (exp_q.size() != 0))
            begin failures++; $display("FAIL sb_valid: got %b exp %b", m_valid, exp_q.size() != 0); end
        if (exp_q.size() != 0) begin
            checks++;
            if (m_data !== exp_q[0])
                begin failures++; $display("FAIL sb_data: got %h exp %h", m_data, exp_q[0]); end
        end
        exp_rinc = !rempty && !fl && (exp_q.size() < 2);
        checks++;
        if (rinc !== exp_rinc)
            begin failures++; $display("FAIL sb_rinc: got %b exp %b", rinc, exp_rinc); end
        if (rinc === 1'b1) rinc_pulses++;
        if (m_valid === 1'b1) valid_cycles++;
        if (m_valid === 1'b1 && rdy) begin
            deliv_q.push_back(m_data);
            if (first_pop_cyc < 0) first_pop_cyc = cyc;
            last_pop_cyc = cyc;
        end
        if (exp_q.size() != 0 && rdy) begin
            w = exp_q.pop_front();
            exp_cnt++;
            pops++;
        end
        if (fl) exp_q.delete();
        if (exp_rinc && fifo_q.size() != 0) exp_q.push_back(fifo_q.pop_front());
        @(posedge rclk);
        #1;
        cyc++;
        rempty = (fifo_q.size() == 0);
        checks++;
        if (xfer_cnt !== 16'(exp_cnt))
            begin failures++; $display("FAIL sb_xfer_cnt: got %0d exp %0d", xfer_cnt, exp_cnt); end
    endtask

    task automatic clear_model();
        fifo_q.delete();
        exp_q.delete();
        deliv_q.delete();
        exp_cnt = 0;
        pops = 0;
        rinc_pulses = 0;
        valid_cycles = 0;
        cyc = 0;
        first_pop_cyc = -1;
        last_pop_cyc = -1;
    endtask

    task automatic do_reset();
        rrst = 1'b1;
        flush = 1'b0;
        m_ready = 1'b0;
        rempty = 1'b1;
        clear_model();
        repeat (2) @(posedge rclk);
        #1;
        rrst = 1'b0;
    endtask

    task automatic run_until(input int n, input int budget);
        int i;
        i = 0;
        while (pops < n && i < budget) begin
            cycle(1'b1, 1'b0);
            i++;
        end
        if (pops < n) begin
            checks++;
            failures++;
            $display("FAIL run_timeout: pops=%0d required %0d", pops, n);
        end
    endtask

    task automatic test_reset();
        #1;
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL rst_valid: got %b exp 0", m_valid); end
        checks++; if (level !== 2'd0) begin failures++; $display("FAIL rst_level: got %0d exp 0", level); end
        checks++; if (xfer_cnt !== 16'd0) begin failures++; $display("FAIL rst_cnt: got %0d exp 0", xfer_cnt); end
        checks++; if (rinc !== 1'b0) begin failures++; $display("FAIL rst_rinc: got %b exp 0", rinc); end
        checks++; if (m_data !== 8'd0) begin failures++; $display("FAIL rst_data: got %h exp 00", m_data); end
        do_reset();
        for (int i = 0; i < 5; i++) fifo_q.push_back(8'($urandom));
        repeat (4) cycle(1'b1, 1'b0);
        repeat (3) cycle(1'b0, 1'b0);
        checks++; if (level !== 2'd2) begin failures++; $display("FAIL pre_rst_level: got %0d exp 2", level); end
        #3;
        rrst = 1'b1;
        #1;
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL async_rst_valid: got %b exp 0", m_valid); end
        checks++; if (level !== 2'd0) begin failures++; $display("FAIL async_rst_level: got %0d exp 0", level); end
        checks++; if (xfer_cnt !== 16'd0) begin failures++; $display("FAIL async_rst_cnt: got %0d exp 0", xfer_cnt); end
        checks++; if (rinc !== 1'b0) begin failures++; $display("FAIL async_rst_rinc: got %b exp 0", rinc); end
        clear_model();
        rempty = 1'b1;
        m_ready = 1'b0;
        @(posedge rclk);
        #1;
        rrst = 1'b0;
        repeat (3) cycle(1'b1, 1'b0);
        checks++; if (rinc_pulses !== 0) begin failures++; $display("FAIL rst_empty_rinc: pulses=%0d exp 0", rinc_pulses); end
    endtask

    task automatic test_single();
        do_reset();
        fifo_q.push_back(8'hA5);
        repeat (5) cycle(1'b1, 1'b0);
        checks++; if (rinc_pulses !== 1) begin failures++; $display("FAIL single_rinc: pulses=%0d exp 1", rinc_pulses); end
        checks++; if (valid_cycles !== 1) begin failures++; $display("FAIL single_valid: cycles=%0d exp 1", valid_cycles); end
        checks++;
        if (deliv_q.size() != 1 || deliv_q[0] !== 8'hA5)
            begin failures++; $display("FAIL single_data: n=%0d exp one word A5", deliv_q.size()); end
        checks++; if (xfer_cnt !== 16'd1) begin failures++; $display("FAIL single_cnt: got %0d exp 1", xfer_cnt); end
        checks++; if (level !== 2'd0) begin failures++; $display("FAIL single_level: got %0d exp 0", level); end
    endtask

    task automatic test_streaming();
        do_reset();
        for (int i = 0; i < 16; i++) fifo_q.push_back(8'(i));
        run_until(16, 40);
        checks++; if (xfer_cnt !== 16'd16) begin failures++; $display("FAIL stream_cnt: got %0d exp 16", xfer_cnt); end
        checks++;
        if (last_pop_cyc - first_pop_cyc != 15)
            begin failures++; $display("FAIL stream_gaps: span=%0d exp 15", last_pop_cyc - first_pop_cyc); end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (i >= deliv_q.size() || deliv_q[i] !== 8'(i))
                begin failures++; $display("FAIL stream_order: idx %0d exp %h", i, 8'(i)); end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] words[8];
        do_reset();
        for (int i = 0; i < 8; i++) begin
            words[i] = 8'($urandom);
            fifo_q.push_back(words[i]);
        end
        repeat (6) cycle(1'b0, 1'b0);
        checks++; if (rinc_pulses !== 2) begin failures++; $display("FAIL bp_rinc: pulses=%0d exp 2", rinc_pulses); end
        checks++; if (level !== 2'd2) begin failures++; $display("FAIL bp_level: got %0d exp 2", level); end
        checks++; if (m_data !== words[0]) begin failures++; $display("FAIL bp_head: got %h exp %h", m_data, words[0]); end
        run_until(8, 30);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (i >= deliv_q.size() || deliv_q[i] !== words[i])
                begin failures++; $display("FAIL bp_order: idx %0d exp %h", i, words[i]); end
        end
    endtask

    task automatic test_flush();
        logic [7:0] words[4];
        do_reset();
        for (int i = 0; i < 4; i++) begin
            words[i] = 8'($urandom);
            fifo_q.push_back(words[i]);
        end
        repeat (4) cycle(1'b0, 1'b0);
        checks++; if (level !== 2'd2) begin failures++; $display("FAIL fl_pre_level: got %0d exp 2", level); end
        cycle(1'b1, 1'b1);
        checks++; if (xfer_cnt !== 16'd1) begin failures++; $display("FAIL fl_cnt: got %0d exp 1", xfer_cnt); end
        flush = 1'b0;
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL fl_valid: got %b exp 0", m_valid); end
        run_until(3, 20);
        checks++;
        if (deliv_q.size() != 3 || deliv_q[0] !== words[0] || deliv_q[1] !== words[2] || deliv_q[2] !== words[3])
            begin failures++; $display("FAIL fl_order: n=%0d exp %h %h %h", deliv_q.size(), words[0], words[2], words[3]); end
    endtask

    task automatic test_random();
        int n;
        do_reset();
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 2) != 0 && fifo_q.size() < 16) fifo_q.push_back(8'($urandom));
            cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0));
        end
        n = 0;
        while ((fifo_q.size() != 0 || exp_q.size() != 0) && n < 60) begin
            cycle(1'b1, 1'b0);
            n++;
        end
        cycle(1'b1, 1'b0);
        checks++; if (level !== 2'd0) begin failures++; $display("FAIL rand_drain_level: got %0d exp 0", level); end
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL rand_drain_valid: got %b exp 0", m_valid); end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 17; i++) fifo_q.push_back(8'($urandom));
        run_until(15, 30);
        checks++; if (xfer_cnt4 !== 4'd15) begin failures++; $display("FAIL wrap_15: got %0d exp 15", xfer_cnt4); end
        run_until(16, 5);
        checks++; if (xfer_cnt4 !== 4'd0) begin failures++; $display("FAIL wrap_16: got %0d exp 0", xfer_cnt4); end
        run_until(17, 5);
        checks++; if (xfer_cnt4 !== 4'd1) begin failures++; $display("FAIL wrap_17: got %0d exp 1", xfer_cnt4); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rrst = 1'b1;
        rempty = 1'b0;
        rdata = 8'h00;
        flush = 1'b0;
        m_ready = 1'b0;
        clear_model();
        test_reset();
        test_single();
        test_streaming();
        test_backpressure();
        test_flush();
        test_random();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
